drr_div_front: RTL and testbench

Front-end stage that feeds `drr_engine_pipe`. It accepts per-packet enqueue requests (class id and packet length) and looks up the class DRR weight in a writable per-class table. It computes length ÷ weight with an iterative restoring divider and emits one single-cycle request carrying class id, weight, quotient and remainder. A small input FIFO decouples bursty arrivals from the multi-cycle divide.

---
 rtl/drr_div_front_if.sv | 41 ++++
 rtl/drr_div_front.sv | 174 +++++++++++++++++
 tb/tb_drr_div_front.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drr_div_front_if.sv
// Bundle of the enqueue, weight-config and result signals of drr_div_front.
// master drives requests/config and observes results; slave is the block itself.
interface drr_div_front_if #(
    parameter int unsigned CLASS_WIDTH  = 5,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned PKT_WIDTH    = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CLASS_WIDTH-1:0]  in_class_id;
    logic [PKT_WIDTH-1:0]    in_pkt_len;

    logic                    cfg_wr_en;
    logic [CLASS_WIDTH-1:0]  cfg_class_id;
    logic [WEIGHT_WIDTH-1:0] cfg_weight;

    logic                    req_valid;
    logic [CLASS_WIDTH-1:0]  req_class_id;
    logic [WEIGHT_WIDTH-1:0] req_class_weight;
    logic [WEIGHT_WIDTH-1:0] req_div_quotient;
    logic [WEIGHT_WIDTH-1:0] req_div_remain;

    logic                    busy;
    logic                    err_zero_weight;

    modport master (
        output in_valid, in_class_id, in_pkt_len,
        output cfg_wr_en, cfg_class_id, cfg_weight,
        input  in_ready,
        input  req_valid, req_class_id, req_class_weight, req_div_quotient, req_div_remain,
        input  busy, err_zero_weight
    );

    modport slave (
        input  in_valid, in_class_id, in_pkt_len,
        input  cfg_wr_en, cfg_class_id, cfg_weight,
        output in_ready,
        output req_valid, req_class_id, req_class_weight, req_div_quotient, req_div_remain,
        output busy, err_zero_weight
    );
endinterface

// File: rtl/drr_div_front.sv
// DRR front end: buffers enqueue requests, looks up the class weight and runs a
// restoring divide of packet length by weight, emitting one result pulse per packet.
module drr_div_front #(
    parameter int unsigned CLASS_WIDTH     = 5,
    parameter int unsigned WEIGHT_WIDTH    = 16,
    parameter int unsigned PKT_WIDTH       = 16,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input logic           clk,
    input logic           rstn,
    drr_div_front_if.slave bus
);
    localparam int unsigned NumClasses = 2 ** CLASS_WIDTH;
    localparam int unsigned FifoDepth  = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned CntW       = (PKT_WIDTH > 1) ? $clog2(PKT_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDiv, StDone} state_e;

    // ---------------- input FIFO ----------------
    logic [CLASS_WIDTH-1:0]     fifo_cls [FifoDepth];
    logic [PKT_WIDTH-1:0]       fifo_len [FifoDepth];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   fifo_cnt_q;
    logic                       fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (fifo_cnt_q == (FIFO_DEPTH_LOG2 + 1)'(FifoDepth));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = bus.in_valid && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cls[wr_ptr_q] <= bus.in_class_id;
            fifo_len[wr_ptr_q] <= bus.in_pkt_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ---------------- weight table ----------------
    logic [WEIGHT_WIDTH-1:0] tbl_q [NumClasses];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NumClasses; i++) tbl_q[i] <= '0;
        end else if (bus.cfg_wr_en) begin
            tbl_q[bus.cfg_class_id] <= bus.cfg_weight;
        end
    end

    // ---------------- divide FSM ----------------
    state_e                  state_q, state_d;
    logic [CLASS_WIDTH-1:0]  cls_q, cls_d;
    logic [PKT_WIDTH-1:0]    dvd_q, dvd_d;
    logic [WEIGHT_WIDTH-1:0] divisor_q, divisor_d;
    logic [WEIGHT_WIDTH-1:0] rem_q, rem_d;
    logic [WEIGHT_WIDTH-1:0] quo_q, quo_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [WEIGHT_WIDTH:0]   shifted;
    logic                    ge;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pop       = 1'b0;
        // Partial remainder stays below the divisor, so one extra bit holds the shift.
        shifted   = {rem_q, dvd_q[PKT_WIDTH-1]};
        ge        = (shifted >= {1'b0, divisor_q});

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cls_d   = fifo_cls[rd_ptr_q];
                    dvd_d   = fifo_len[rd_ptr_q];
                    state_d = StLoad;
                end
            end
            StLoad: begin
                divisor_d = tbl_q[cls_q];
                if (divisor_d == '0) begin
                    quo_d   = '1;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    quo_d   = '0;
                    rem_d   = '0;
                    cnt_d   = CntW'(PKT_WIDTH - 1);
                    state_d = StDiv;
                end
            end
            StDiv: begin
                dvd_d = dvd_q << 1;
                quo_d = {quo_q[WEIGHT_WIDTH-2:0], ge};
                if (ge) rem_d = WEIGHT_WIDTH'(shifted - {1'b0, divisor_q});
                else    rem_d = shifted[WEIGHT_WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    logic                    req_valid_q;
    logic [CLASS_WIDTH-1:0]  req_cls_q;
    logic [WEIGHT_WIDTH-1:0] req_w_q, req_quo_q, req_rem_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cls_q       <= '0;
            dvd_q       <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_cls_q   <= '0;
            req_w_q     <= '0;
            req_quo_q   <= '0;
            req_rem_q   <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            dvd_q       <= dvd_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            // DONE lasts one cycle, so the pulse can never repeat back to back.
            req_valid_q <= (state_d == StDone);
            if (state_d == StDone) begin
                req_cls_q <= cls_q;
                req_w_q   <= divisor_d;
                req_quo_q <= quo_d;
                req_rem_q <= rem_d;
            end
        end
    end

    assign bus.in_ready         = !fifo_full;
    assign bus.req_valid        = req_valid_q;
    assign bus.req_class_id     = req_cls_q;
    assign bus.req_class_weight = req_w_q;
    assign bus.req_div_quotient = req_quo_q;
    assign bus.req_div_remain   = req_rem_q;
    assign bus.busy             = (state_q != StIdle) || !fifo_empty;
    assign bus.err_zero_weight  = err_q;

endmodule

// File: tb/tb_drr_div_front.sv
// Self-checking bench for drr_div_front: directed scenarios plus randomized bursts
// checked against a plain-arithmetic model of the weight table and divide.
module tb_drr_div_front;
    logic clk;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [15:0] model_w [32];

    typedef struct {
        logic [4:0]  c;
        logic [15:0] w;
        logic [15:0] q;
        logic [15:0] r;
    } exp_t;
    exp_t exp_q[$];

    drr_div_front_if #(.CLASS_WIDTH(5), .WEIGHT_WIDTH(16), .PKT_WIDTH(16)) bus ();

    drr_div_front #(
        .CLASS_WIDTH(5), .WEIGHT_WIDTH(16), .PKT_WIDTH(16), .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input int c, input logic [15:0] w);
        bus.cfg_wr_en    = 1'b1;
        bus.cfg_class_id = 5'(c);
        bus.cfg_weight   = w;
        @(posedge clk);
        #1;
        bus.cfg_wr_en = 1'b0;
        model_w[c]    = w;
    endtask

    task automatic push(input int c, input int len, output int waited, output int acc);
        bus.in_valid    = 1'b1;
        bus.in_class_id = 5'(c);
        bus.in_pkt_len  = 16'(len);
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: in_ready stayed 0, wanted 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit got, output int at,
                            output logic [4:0] c, output logic [15:0] w,
                            output logic [15:0] q, output logic [15:0] r);
        got = 1'b0; at = 0; c = '0; w = '0; q = '0; r = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.req_valid) begin
                got = 1'b1; at = cyc;
                c = bus.req_class_id; w = bus.req_class_weight;
                q = bus.req_div_quotient; r = bus.req_div_remain;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 32; i++) model_w[i] = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_req_valid: got %b want 0", bus.req_valid); end
        n_cmp++; if (bus.req_class_id !== 5'd0) begin n_err++;
            $display("FAIL reset_class: got %h want 0", bus.req_class_id); end
        n_cmp++; if (bus.req_class_weight !== 16'd0) begin n_err++;
            $display("FAIL reset_weight: got %h want 0", bus.req_class_weight); end
        n_cmp++; if (bus.req_div_quotient !== 16'd0) begin n_err++;
            $display("FAIL reset_quotient: got %h want 0", bus.req_div_quotient); end
        n_cmp++; if (bus.req_div_remain !== 16'd0) begin n_err++;
            $display("FAIL reset_remain: got %h want 0", bus.req_div_remain); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.err_zero_weight !== 1'b0) begin n_err++;
            $display("FAIL reset_err: got %b want 0", bus.err_zero_weight); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int w8, acc, at; bit got; logic [4:0] c; logic [15:0] w, q, r;
        cfg_write(3, 16'd100);
        wait_idle();
        push(3, 1500, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || (at - acc + 1) != 19) begin n_err++;
            $display("FAIL basic_latency: got=%0b cycle %0d want cycle 19", got, at - acc + 1); end
        n_cmp++; if (c !== 5'd3 || w !== 16'd100) begin n_err++;
            $display("FAIL basic_class_weight: got %0d/%0d want 3/100", c, w); end
        n_cmp++; if (q !== 16'd15 || r !== 16'd0) begin n_err++;
            $display("FAIL basic_div: got q=%0d r=%0d want q=15 r=0", q, r); end
        @(negedge clk);
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_err++;
            $display("FAIL basic_single_pulse: req_valid %b want 0", bus.req_valid); end
        n_cmp++; if (bus.req_div_quotient !== 16'd15) begin n_err++;
            $display("FAIL basic_hold: quotient %0d want 15", bus.req_div_quotient); end
    endtask

    task automatic test_remainder();
        int w8, acc, at; bit got; logic [4:0] c; logic [15:0] w, q, r;
        cfg_write(7, 16'd300);
        push(7, 1000, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || q !== 16'd3 || r !== 16'd100) begin n_err++;
            $display("FAIL rem_1000: got=%0b q=%0d r=%0d want q=3 r=100", got, q, r); end
        push(7, 299, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || q !== 16'd0 || r !== 16'd299) begin n_err++;
            $display("FAIL rem_299: got=%0b q=%0d r=%0d want q=0 r=299", got, q, r); end
    endtask

    task automatic test_zero_weight();
        int w8, acc, at; bit got; logic [4:0] c; logic [15:0] w, q, r;
        wait_idle();
        push(9, 64, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || (at - acc + 1) != 3) begin n_err++;
            $display("FAIL zero_latency: got=%0b cycle %0d want cycle 3", got, at - acc + 1); end
        n_cmp++; if (q !== 16'hFFFF || r !== 16'd0 || w !== 16'd0 || c !== 5'd9) begin n_err++;
            $display("FAIL zero_result: c=%0d w=%0d q=%h r=%0d want 9/0/ffff/0", c, w, q, r); end
        n_cmp++; if (bus.err_zero_weight !== 1'b1) begin n_err++;
            $display("FAIL zero_err_set: got %b want 1", bus.err_zero_weight); end
        push(7, 600, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || q !== 16'd2 || r !== 16'd0) begin n_err++;
            $display("FAIL zero_next_div: q=%0d r=%0d want 2/0", q, r); end
        n_cmp++; if (bus.err_zero_weight !== 1'b1) begin n_err++;
            $display("FAIL zero_err_sticky: got %b want 1", bus.err_zero_weight); end
    endtask

    task automatic test_back_to_back();
        int waited [6];
        int acc [6];
        int at [6];
        cfg_write(1, 16'd1);
        wait_idle();
        fork
            begin
                for (int i = 0; i < 6; i++) push(1, 10 + i, waited[i], acc[i]);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    bit got; logic [4:0] c; logic [15:0] w, q, r;
                    wait_req(200, got, at[k], c, w, q, r);
                    n_cmp++; if (!got || c !== 5'd1 || q !== 16'(10 + k) || r !== 16'd0) begin
                        n_err++;
                        $display("FAIL b2b_result%0d: got=%0b c=%0d q=%0d r=%0d want 1/%0d/0",
                                 k, got, c, q, r, 10 + k);
                    end
                    if (k > 0) begin
                        n_cmp++; if (at[k] - at[k-1] != 18) begin n_err++;
                            $display("FAIL b2b_spacing%0d: got %0d want 18", k,
                                     at[k] - at[k-1]); end
                    end
                end
            end
        join
        n_cmp++; if (waited[0] + waited[1] + waited[2] + waited[3] + waited[4] != 0) begin
            n_err++;
            $display("FAIL b2b_first_five_stalled: waits %0d want 0",
                     waited[0] + waited[1] + waited[2] + waited[3] + waited[4]);
        end
        n_cmp++; if (waited[5] == 0) begin n_err++;
            $display("FAIL b2b_in_ready_drop: sixth push waited %0d want >0", waited[5]); end
    endtask

    task automatic test_cfg_snapshot();
        int w8, acc, at; bit got; logic [4:0] c; logic [15:0] w, q, r;
        cfg_write(2, 16'd250);
        wait_idle();
        push(2, 1000, w8, acc);
        repeat (4) begin @(posedge clk); #1; end
        cfg_write(2, 16'd7);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || q !== 16'd4 || r !== 16'd0 || w !== 16'd250) begin n_err++;
            $display("FAIL snap_old_weight: w=%0d q=%0d r=%0d want 250/4/0", w, q, r); end
        push(2, 1000, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || w !== model_w[2] || q !== 16'(1000 / 7) || r !== 16'(1000 % 7))
        begin n_err++;
            $display("FAIL snap_new_weight: w=%0d q=%0d r=%0d want 7/142/6", w, q, r); end
    endtask

    task automatic test_reset_mid();
        int w8, acc, at, a1; bit got; logic [4:0] c; logic [15:0] w, q, r;
        wait_idle();
        push(1, 20, w8, a1);
        push(1, 21, w8, acc);
        push(1, 22, w8, acc);
        repeat (3) begin @(posedge clk); #1; end
        pulse_reset();
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL rmid_flush: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready); end
        n_cmp++; if (bus.err_zero_weight !== 1'b0 || bus.req_valid !== 1'b0) begin n_err++;
            $display("FAIL rmid_clear: err=%b req_valid=%b want 0/0",
                     bus.err_zero_weight, bus.req_valid); end
        wait_req(60, got, at, c, w, q, r);
        n_cmp++; if (got) begin n_err++;
            $display("FAIL rmid_no_result: req_valid seen=%0b want 0", got); end
        @(posedge clk);
        #1;
        push(1, 5, w8, acc);
        wait_req(40, got, at, c, w, q, r);
        n_cmp++; if (!got || (at - acc + 1) != 3 || w !== model_w[1] || q !== 16'hFFFF) begin
            n_err++;
            $display("FAIL rmid_table_cleared: cycle %0d w=%0d q=%h want 3/0/ffff",
                     at - acc + 1, w, q);
        end
    endtask

    task automatic test_random();
        int wr_cls [8];
        bit sticky;
        pulse_reset();
        sticky = 1'b0;
        for (int round = 0; round < 3; round++) begin
            wait_idle();
            for (int i = 0; i < 8; i++) begin
                logic [15:0] wv;
                int sel;
                wr_cls[i] = $urandom_range(0, 31);
                sel = $urandom_range(0, 7);
                if (sel == 0)      wv = 16'd0;
                else if (sel < 4)  wv = 16'($urandom_range(1, 15));
                else               wv = 16'($urandom_range(1, 65535));
                cfg_write(wr_cls[i], wv);
            end
            fork
                begin
                    for (int n = 0; n < 10; n++) begin
                        exp_t e; int len, w8, acc, gap;
                        e.c = 5'(wr_cls[$urandom_range(0, 7)]);
                        len = $urandom_range(0, 65535);
                        e.w = model_w[e.c];
                        if (e.w == 16'd0) begin e.q = 16'hFFFF; e.r = 16'd0; end
                        else begin e.q = 16'(len / e.w); e.r = 16'(len % e.w); end
                        exp_q.push_back(e);
                        push(e.c, len, w8, acc);
                        gap = $urandom_range(0, 25);
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                end
                begin
                    int prev_at = 0;
                    for (int n = 0; n < 10; n++) begin
                        bit got; int at; logic [4:0] c; logic [15:0] w, q, r; exp_t e;
                        wait_req(400, got, at, c, w, q, r);
                        n_cmp++;
                        if (!got || exp_q.size() == 0) begin n_err++;
                            $display("FAIL rand_missing: got=%0b queued=%0d", got, exp_q.size());
                        end else begin
                            e = exp_q.pop_front();
                            if (e.w == 16'd0) sticky = 1'b1;
                            if (c !== e.c || w !== e.w || q !== e.q || r !== e.r) begin n_err++;
                                $display("FAIL rand_result: got c=%0d w=%0d q=%0d r=%0d want %0d/%0d/%0d/%0d",
                                         c, w, q, r, e.c, e.w, e.q, e.r);
                            end
                            n_cmp++; if (bus.err_zero_weight !== sticky) begin n_err++;
                                $display("FAIL rand_err: got %b want %b", bus.err_zero_weight, sticky);
                            end
                            if (n > 0) begin
                                n_cmp++; if (at - prev_at < 2) begin n_err++;
                                    $display("FAIL rand_pulse_gap: got %0d want >=2", at - prev_at);
                                end
                            end
                            prev_at = at;
                        end
                    end
                end
            join
            exp_q.delete();
        end
    endtask

    initial begin
        rstn             = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_class_id  = '0;
        bus.in_pkt_len   = '0;
        bus.cfg_wr_en    = 1'b0;
        bus.cfg_class_id = '0;
        bus.cfg_weight   = '0;
        for (int i = 0; i < 32; i++) model_w[i] = '0;
        test_reset();
        test_basic();
        test_remainder();
        test_zero_weight();
        test_back_to_back();
        test_cfg_snapshot();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
